// File: rtl/regdst_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (req0)
// and load-return (req1) write-back paths; address, data, select and enable are registered.
module regdst_write_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  wb_stall,
    output logic                  mux_select,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  reg_write,
    output logic [CNT_WIDTH-1:0]  zero_drops
);

    logic                  grant0, grant1, xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  reg_write_q, reg_write_d;
    logic                  mux_select_q, mux_select_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [CNT_WIDTH-1:0]  zero_drops_q, zero_drops_d;

    // Readies stay low during reset so nothing is accepted into a clearing pipeline.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && !wb_stall) begin
            if (req0_valid && (!req1_valid || last_grant_q))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
        xfer     = grant0 | grant1;
        sel_addr = grant1 ? req1_addr : req0_addr;
        sel_data = grant1 ? req1_data : req0_data;
    end

    // State register: reg_write doubles as the IDLE/WRITE state bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            mux_select_q <= 1'b0;
            last_grant_q <= 1'b1;
            write_addr_q <= '0;
            write_data_q <= '0;
            zero_drops_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mux_select_q <= mux_select_d;
            last_grant_q <= last_grant_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            zero_drops_q <= zero_drops_d;
        end
    end

    // Next state: a stall freezes the presented write, including its enable.
    always_comb begin
        reg_write_d = reg_write_q;
        if (xfer)
            reg_write_d = (sel_addr != '0);
        else if (!wb_stall)
            reg_write_d = 1'b0;
    end

    // Datapath registers; writes to register 0 are dropped and counted.
    always_comb begin
        mux_select_d = mux_select_q;
        last_grant_d = last_grant_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        zero_drops_d = zero_drops_q;
        if (xfer) begin
            mux_select_d = grant1;
            last_grant_d = grant1;
            write_addr_d = sel_addr;
            write_data_d = sel_data;
            if (sel_addr == '0 && !(&zero_drops_q))
                zero_drops_d = zero_drops_q + CNT_WIDTH'(1);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign mux_select = mux_select_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign reg_write  = reg_write_q;
    assign zero_drops = zero_drops_q;

endmodule

// File: tb/tb_regdst_write_arbiter.sv
// Directed bench for regdst_write_arbiter: inputs change 1ns after posedge,
// readies are checked 1ns later, registered outputs 1ns after the next posedge.
module tb_regdst_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, wb_stall;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        mux_select, reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [7:0]  zero_drops;

    int checks = 0;
    int failures = 0;

    regdst_write_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .wb_stall(wb_stall), .mux_select(mux_select), .write_addr(write_addr),
        .write_data(write_data), .reg_write(reg_write), .zero_drops(zero_drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic rw, input logic [4:0] a,
                           input logic [31:0] d, input logic sel);
        chk({tag, ".reg_write"}, 32'(reg_write), 32'(rw));
        chk({tag, ".write_addr"}, 32'(write_addr), 32'(a));
        chk({tag, ".write_data"}, write_data, d);
        chk({tag, ".mux_select"}, 32'(mux_select), 32'(sel));
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(r0));
        chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(r1));
    endtask

    initial begin
        rst_n = 1'b0; wb_stall = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h2;
        tick(); tick();
        // Reset state: readies forced low even though both requesters are valid
        chk_rdy("rst", 1'b0, 1'b0);
        chk_out("rst", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("rst.zero_drops", 32'(zero_drops), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle.reg_write", 32'(reg_write), 32'd0);

        // req0 alone
        req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'hDEADBEEF;
        #1 chk_rdy("t1", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0;
        chk_out("t1.wr", 1'b1, 5'd8, 32'hDEADBEEF, 1'b0);
        tick();
        chk_out("t1.idle", 1'b0, 5'd8, 32'hDEADBEEF, 1'b0);

        // req1 alone, leaves last_grant=1
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h33;
        #1 chk_rdy("r1", 1'b0, 1'b1);
        tick();
        req1_valid = 1'b0;
        chk_out("r1.wr", 1'b1, 5'd3, 32'h33, 1'b1);

        // Contention: strict alternation 0,1,0,1
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA1;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            #1 chk_rdy($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
            tick();
            if (i % 2 == 0) chk_out($sformatf("rr%0d", i), 1'b1, 5'd1, 32'hA1, 1'b0);
            else            chk_out($sformatf("rr%0d", i), 1'b1, 5'd2, 32'hB2, 1'b1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Zero-register writes: dropped and counted, saturating at 255
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
        #1 chk_rdy("z", 1'b0, 1'b1);
        tick();
        chk_out("z.first", 1'b0, 5'd0, 32'hFFFFFFFF, 1'b1);
        chk("z.cnt1", 32'(zero_drops), 32'd1);
        for (int i = 2; i <= 300; i++) begin
            tick();
            if (i == 254) chk("z.cnt254", 32'(zero_drops), 32'd254);
            if (i == 256) chk("z.cnt256", 32'(zero_drops), 32'd255);
        end
        chk("z.cnt300", 32'(zero_drops), 32'd255);
        chk("z.rw", 32'(reg_write), 32'd0);
        req1_valid = 1'b0;

        // Stall holds the presented write
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        #1 chk_rdy("s.xfer", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0;
        chk_out("s.wr", 1'b1, 5'd9, 32'h99, 1'b0);
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44; wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk_rdy($sformatf("s%0d", i), 1'b0, 1'b0);
            tick();
            chk_out($sformatf("s%0d", i), 1'b1, 5'd9, 32'h99, 1'b0);
        end
        wb_stall = 1'b0;
        #1 chk_rdy("s.rel", 1'b0, 1'b1);
        tick();
        req1_valid = 1'b0;
        chk_out("s.rel", 1'b1, 5'd4, 32'h44, 1'b1);
        tick();
        chk("s.idle", 32'(reg_write), 32'd0);

        // Reset mid-cycle after a grant: write lost, req0 first afterwards
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hC1;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hC2;
        #1 chk_rdy("mr.grant", 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk_rdy("mr.in", 1'b0, 1'b0);
        chk_out("mr.in", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("mr.zero_drops", 32'(zero_drops), 32'd0);
        tick();
        chk_out("mr.edge", 1'b0, 5'd0, 32'h0, 1'b0);
        rst_n = 1'b1;
        #1 chk_rdy("mr.post", 1'b1, 1'b0);
        tick();
        chk_out("mr.post", 1'b1, 5'd1, 32'hC1, 1'b0);
        #1 chk_rdy("mr.next", 1'b0, 1'b1);
        tick();
        chk_out("mr.next", 1'b1, 5'd2, 32'hC2, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regdst_write_arbiter.md
Name: regdst_write_arbiter

Overview:
- Shares the register-file write port, and the 5-bit destination-address mux and data mux that feed it, between two write-back requesters.
- Requester 0 is the ALU result path; requester 1 is the load/memory return path.
- Arbitrates round-robin with a valid/ready handshake and drives the mux select, address, data and write-enable from registers.
- Sits between the execute/memory stages and the register file; the register file can back-pressure it via a stall input.

Parameters:
- ADDR_WIDTH, 5, width of the destination register address (32 registers).
- DATA_WIDTH, 32, width of the write-back data.
- CNT_WIDTH, 8, width of the saturating zero-register drop counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  ADDR_WIDTH  requester 0 destination register.
- req0_data  input  DATA_WIDTH  requester 0 write data.
- req0_ready  output  1  requester 0 granted this cycle (combinational).
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  ADDR_WIDTH  requester 1 destination register.
- req1_data  input  DATA_WIDTH  requester 1 write data.
- req1_ready  output  1  requester 1 granted this cycle (combinational).
- wb_stall  input  1  register file cannot accept a write this cycle.
- mux_select  output  1  select for the downstream address/data 2:1 muxes (0 = req0, 1 = req1), registered.
- write_addr  output  ADDR_WIDTH  registered destination address.
- write_data  output  DATA_WIDTH  registered write data.
- reg_write  output  1  registered register-file write enable.
- zero_drops  output  CNT_WIDTH  count of accepted writes targeting register 0, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - mux_select=0, write_addr=0, write_data=0, reg_write=0, zero_drops=0.
  - Internal last_grant=1, so req0 wins the first contention.
  - req0_ready and req1_ready are forced 0 while rst_n=0.
- Grant (combinational, only when wb_stall=0):
  - Only reqN_valid=1: grant N.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant.
  - reqN_ready=1 exactly when N is granted. At most one ready is high per cycle.
- Transfer occurs when reqN_valid and reqN_ready are both high.
- On the clock edge after a transfer from N:
  - write_addr<=reqN_addr, write_data<=reqN_data, mux_select<=N, last_grant<=N.
  - reg_write<=1 if reqN_addr!=0. Otherwise reg_write<=0 and zero_drops increments, saturating at all-ones.
- Latency: exactly 1 cycle from the transfer edge to reg_write/address/data visible.
- No transfer and wb_stall=0: reg_write<=0. mux_select, write_addr and write_data hold; last_grant holds.
- wb_stall=1:
  - Both readies are 0.
  - All registered outputs, including reg_write, hold their values, so the current write stays presented until the stall clears.
  - last_grant holds.
- Requester rule: once valid is high, valid, addr and data stay stable until ready. The arbiter never grants a requester whose valid is 0.
- Fairness: with both valid continuously and no stall, grants strictly alternate 0,1,0,1,… A requester waits at most one transfer.
- State summary (2 states, encoded by reg_write):
  - IDLE (reg_write=0) goes to WRITE on a transfer with nonzero addr.
  - WRITE goes to IDLE on no transfer or a zero-addr transfer. WRITE stays WRITE on a nonzero-addr transfer or on stall.
- Reset mid-operation: outputs clear immediately and any write accepted on that cycle is lost. Requesters keep valid asserted and are re-granted after rst_n rises; req0 wins first.
- Arithmetic: zero_drops is unsigned and saturates without wrapping. No other arithmetic.

Test Plan:
- Reset, then req0 only, addr=5'd8, data=32'hDEADBEEF: req0_ready=1 in the same cycle; next cycle reg_write=1, write_addr=8, write_data=DEADBEEF, mux_select=0; following cycle reg_write=0.
- Both valid continuously for 4 cycles (req0 addr=1, req1 addr=2): grant order 0,1,0,1; mux_select registers 0,1,0,1; write_addr 1,2,1,2.
- req1 valid with addr=0, data=32'hFFFFFFFF: req1_ready=1; next cycle reg_write=0, write_addr=0, zero_drops=1. Repeating 300 times gives zero_drops=255, with no wrap.
- Transfer req0 addr=9, then wb_stall=1 for 3 cycles with req1 valid: both readies 0; reg_write=1 and write_addr=9 held for 3 cycles; req1 granted on the first unstalled cycle.
- Both valid, drop rst_n mid-cycle after a grant: outputs go to 0 immediately and that write never appears. After release, req0 is granted first.
